// File: rtl/inst_fetch_burst_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : inst_fetch_burst_ctrl_pkg
// Brief    : Shared FSM state encodings and default instruction width for the
//            burst instruction fetch controller.
// Revision : 1.0
// ============================================================================
package inst_fetch_burst_ctrl_pkg;

    localparam int c_INST_BITS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/inst_fetch_burst_ctrl_fifo.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_fifo
// Brief    : Show-ahead FIFO with synchronous flush and free-slot count.
// Revision : 1.0
// ============================================================================
module inst_fetch_fifo #(
    parameter int P_WIDTH      = 50,
    parameter int P_DEPTH      = 8,
    parameter int P_DEPTH_LOG2 = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_flush,
    input  logic                    i_push,
    input  logic [P_WIDTH-1:0]      i_wdata,
    input  logic                    i_pop,
    output logic [P_WIDTH-1:0]      o_rdata,
    output logic                    o_valid,
    output logic                    o_empty,
    output logic [P_DEPTH_LOG2:0]   o_free
);

    localparam logic [P_DEPTH_LOG2:0] c_DEPTH = (P_DEPTH_LOG2 + 1)'(P_DEPTH);

    logic [P_WIDTH-1:0]      r_mem [P_DEPTH];
    logic [P_DEPTH_LOG2-1:0] r_rd_ptr;
    logic [P_DEPTH_LOG2-1:0] r_wr_ptr;
    logic [P_DEPTH_LOG2:0]   r_count;
    logic                    w_pop;
    logic                    w_push;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != c_DEPTH) || w_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
    end

    // Head is forced to zero when empty so stale entries never leak out.
    assign o_valid = (r_count != '0);
    assign o_empty = !o_valid;
    assign o_rdata = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_free  = c_DEPTH - r_count;

endmodule
`default_nettype wire

// File: rtl/inst_fetch_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_burst_ctrl
// Brief    : Avalon-MM burst instruction fetcher feeding a show-ahead FIFO,
//            with jr/jal/j redirect flush. INST_FETCH_JAL_LINK_EN enables the
//            jal return-address output.
// Revision : 1.0
// ============================================================================
module inst_fetch_burst_ctrl
    import inst_fetch_burst_ctrl_pkg::*;
#(
    parameter int                     P_ADDR_BITS       = 18,
    parameter int                     P_INST_BITS       = c_INST_BITS,
    parameter int                     P_FIFO_DEPTH      = 8,
    parameter int                     P_FIFO_DEPTH_LOG2 = 3,
    parameter int                     P_BURST_LEN       = 4,
    parameter int                     P_BURST_BITS      = 3,
    parameter logic [P_ADDR_BITS-1:0] P_RESET_PC        = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [P_ADDR_BITS-1:0]  i_jr_addr,
    input  logic [P_ADDR_BITS-1:0]  i_j_addr,
    input  logic [P_ADDR_BITS-1:0]  i_jal_addr,
    input  logic                    i_jr_valid,
    input  logic                    i_j_valid,
    input  logic                    i_jal_valid,
    output logic [P_ADDR_BITS-1:0]  o_ret_addr,
    output logic                    o_ret_addr_valid,
    output logic [P_INST_BITS-1:0]  o_inst,
    output logic [P_ADDR_BITS-1:0]  o_inst_pc,
    output logic                    o_inst_valid,
    input  logic                    i_inst_complete,
    output logic                    o_inst_empty,
    output logic                    o_rst_inst_fifo,
    output logic [P_ADDR_BITS-1:0]  o_addr,
    output logic [P_BURST_BITS-1:0] o_burstcount,
    output logic                    o_read,
    input  logic                    i_waitrequest,
    input  logic [P_INST_BITS-1:0]  i_readdata,
    input  logic                    i_readdatavalid
);

    localparam logic [P_BURST_BITS-1:0]      c_BURST        = P_BURST_BITS'(P_BURST_LEN);
    localparam logic [P_BURST_BITS-1:0]      c_LAST_BEAT    = P_BURST_BITS'(P_BURST_LEN - 1);
    localparam logic [P_FIFO_DEPTH_LOG2:0]   c_BURST_SLOTS  = (P_FIFO_DEPTH_LOG2 + 1)'(P_BURST_LEN);
    localparam logic [P_ADDR_BITS-1:0]       c_BURST_STRIDE = P_ADDR_BITS'(P_BURST_LEN);

    fetch_state_t                   r_state;
    logic [P_ADDR_BITS-1:0]         r_fetch_pc;
    logic [P_ADDR_BITS-1:0]         r_addr;
    logic                           r_read;
    logic                           r_discard;
    logic                           r_flush_pulse;
    logic [P_BURST_BITS-1:0]        r_beat_cnt;

    logic                           w_redir;
    logic [P_ADDR_BITS-1:0]         w_target;
    logic                           w_push;
    logic                           w_pop;
    logic [P_ADDR_BITS-1:0]         w_beat_pc;
    logic [P_FIFO_DEPTH_LOG2:0]     w_free;
    logic [P_ADDR_BITS+P_INST_BITS-1:0] w_head;

    always_comb begin
        w_redir  = i_jr_valid | i_jal_valid | i_j_valid;
        w_target = i_j_addr;
        if (i_jr_valid)       w_target = i_jr_addr;
        else if (i_jal_valid) w_target = i_jal_addr;
    end

    // r_addr still holds the accepted burst base throughout DATA.
    assign w_beat_pc = r_addr + P_ADDR_BITS'(r_beat_cnt);
    assign w_push    = (r_state == ST_DATA) && i_readdatavalid && !r_discard && !w_redir;
    assign w_pop     = i_inst_complete && !w_redir;

    inst_fetch_fifo #(
        .P_WIDTH      (P_ADDR_BITS + P_INST_BITS),
        .P_DEPTH      (P_FIFO_DEPTH),
        .P_DEPTH_LOG2 (P_FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_redir),
        .i_push  (w_push),
        .i_wdata ({w_beat_pc, i_readdata}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_valid (o_inst_valid),
        .o_empty (o_inst_empty),
        .o_free  (w_free)
    );

    assign o_inst_pc = w_head[P_ADDR_BITS+P_INST_BITS-1:P_INST_BITS];
    assign o_inst    = w_head[P_INST_BITS-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_fetch_pc    <= P_RESET_PC;
            r_addr        <= P_RESET_PC;
            r_read        <= 1'b0;
            r_discard     <= 1'b0;
            r_beat_cnt    <= '0;
            r_flush_pulse <= 1'b0;
        end else begin
            r_flush_pulse <= w_redir;
            if (w_redir) r_fetch_pc <= w_target;
            case (r_state)
                ST_IDLE: begin
                    if (!w_redir && (w_free >= c_BURST_SLOTS)) begin
                        r_state <= ST_REQ;
                        r_read  <= 1'b1;
                        r_addr  <= r_fetch_pc;
                    end
                end
                ST_REQ: begin
                    if (w_redir) r_discard <= 1'b1;
                    if (!i_waitrequest) begin
                        r_read     <= 1'b0;
                        r_state    <= ST_DATA;
                        r_beat_cnt <= '0;
                        // A pending redirect owns the fetch PC; do not advance past it.
                        if (!w_redir && !r_discard) r_fetch_pc <= r_fetch_pc + c_BURST_STRIDE;
                    end
                end
                ST_DATA: begin
                    if (w_redir) r_discard <= 1'b1;
                    if (i_readdatavalid) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (r_beat_cnt == c_LAST_BEAT) begin
                            r_state   <= ST_IDLE;
                            r_discard <= 1'b0;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_read          = r_read;
    assign o_addr          = r_addr;
    assign o_burstcount    = c_BURST;
    assign o_rst_inst_fifo = r_flush_pulse;

`ifdef INST_FETCH_JAL_LINK_EN
    logic [P_ADDR_BITS-1:0] r_ret_addr;
    logic                   r_ret_valid;
    logic                   w_jal_take;

    assign w_jal_take = i_jal_valid && !i_jr_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ret_addr  <= '0;
            r_ret_valid <= 1'b0;
        end else begin
            r_ret_valid <= w_jal_take;
            if (w_jal_take) r_ret_addr <= o_inst_pc + 1'b1;
        end
    end

    assign o_ret_addr       = r_ret_addr;
    assign o_ret_addr_valid = r_ret_valid;
`else
    assign o_ret_addr       = '0;
    assign o_ret_addr_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_burst_ctrl
// Brief    : Self-checking bench for inst_fetch_burst_ctrl with an Avalon
//            memory model returning 0x100+addr and a contiguous-stream model.
// Revision : 1.0
// ============================================================================
module tb_inst_fetch_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [17:0] i_jr_addr = '0, i_j_addr = '0, i_jal_addr = '0;
    logic        i_jr_valid = 1'b0, i_j_valid = 1'b0, i_jal_valid = 1'b0;
    logic        i_inst_complete = 1'b0;
    logic        i_waitrequest = 1'b0;
    logic [31:0] i_readdata = '0;
    logic        i_readdatavalid = 1'b0;
    logic [17:0] o_ret_addr, o_inst_pc, o_addr;
    logic        o_ret_addr_valid, o_inst_valid, o_inst_empty, o_rst_inst_fifo, o_read;
    logic [31:0] o_inst;
    logic [2:0]  o_burstcount;

    always #5 clk = ~clk;

    inst_fetch_burst_ctrl dut (
        .clk(clk), .rst(rst),
        .i_jr_addr(i_jr_addr), .i_j_addr(i_j_addr), .i_jal_addr(i_jal_addr),
        .i_jr_valid(i_jr_valid), .i_j_valid(i_j_valid), .i_jal_valid(i_jal_valid),
        .o_ret_addr(o_ret_addr), .o_ret_addr_valid(o_ret_addr_valid),
        .o_inst(o_inst), .o_inst_pc(o_inst_pc), .o_inst_valid(o_inst_valid),
        .i_inst_complete(i_inst_complete), .o_inst_empty(o_inst_empty),
        .o_rst_inst_fifo(o_rst_inst_fifo),
        .o_addr(o_addr), .o_burstcount(o_burstcount), .o_read(o_read),
        .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
        .i_readdatavalid(i_readdatavalid)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [17:0] beat_q[$];
    logic [17:0] req_addr_q[$];
    logic [2:0]  req_bc_q[$];
    int wait_pct = 0, gap_pct = 0, forced_wait = 0;

    function automatic logic [31:0] mem_word(input logic [17:0] a);
        return 32'h100 + {14'd0, a};
    endfunction

    // Avalon memory model: one beat per cycle (optionally gapped), first beat
    // one cycle after acceptance.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            beat_q.delete();
            i_waitrequest   = 1'b0;
            i_readdatavalid = 1'b0;
            i_readdata      = '0;
        end else begin
            if (beat_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
                i_readdatavalid = 1'b1;
                i_readdata      = mem_word(beat_q.pop_front());
            end else begin
                i_readdatavalid = 1'b0;
                i_readdata      = '0;
            end
            if (o_read && forced_wait > 0) begin
                i_waitrequest = 1'b1;
                forced_wait--;
            end else begin
                i_waitrequest = ($urandom_range(99) < wait_pct);
            end
            if (o_read && !i_waitrequest) begin
                req_addr_q.push_back(o_addr);
                req_bc_q.push_back(o_burstcount);
                for (int k = 0; k < int'(o_burstcount); k++) beat_q.push_back(o_addr + 18'(k));
            end
        end
    end

    task automatic clear_inputs();
        i_jr_valid = 1'b0; i_j_valid = 1'b0; i_jal_valid = 1'b0;
        i_inst_complete = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        forced_wait = 0;
        repeat (2) @(negedge clk);
        req_addr_q.delete();
        req_bc_q.delete();
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < budget; t++) begin
            if (o_inst_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_read(input int budget, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < budget; t++) begin
            if (o_read) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_reqs(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < budget; t++) begin
            if (req_addr_q.size() >= n) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; clear_inputs(); wait_pct = 0; gap_pct = 0; forced_wait = 0;
        repeat (2) @(negedge clk);
        n_checks++; if (o_read !== 1'b0) $display("FAIL reset_o_read got=%0b exp=0", o_read); else n_pass++;
        n_checks++; if (o_addr !== 18'h0) $display("FAIL reset_o_addr got=%0h exp=0", o_addr); else n_pass++;
        n_checks++; if (o_burstcount !== 3'd4) $display("FAIL reset_burstcount got=%0d exp=4", o_burstcount); else n_pass++;
        n_checks++; if (o_inst_valid !== 1'b0 || o_inst_empty !== 1'b1) $display("FAIL reset_fifo valid=%0b empty=%0b exp=0/1", o_inst_valid, o_inst_empty); else n_pass++;
        n_checks++; if (o_inst !== 32'h0 || o_inst_pc !== 18'h0) $display("FAIL reset_head inst=%0h pc=%0h exp=0/0", o_inst, o_inst_pc); else n_pass++;
        n_checks++; if (o_rst_inst_fifo !== 1'b0 || o_ret_addr !== 18'h0 || o_ret_addr_valid !== 1'b0)
            $display("FAIL reset_misc flush=%0b ret=%0h retv=%0b exp=0/0/0", o_rst_inst_fifo, o_ret_addr, o_ret_addr_valid); else n_pass++;
        req_addr_q.delete(); req_bc_q.delete();
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (o_read !== 1'b1 || o_addr !== 18'h0) $display("FAIL reset_first_read read=%0b addr=%0h exp=1/0", o_read, o_addr); else n_pass++;
    endtask

    task automatic test_stream();
        int got = 0;
        bit ok;
        for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
            i_inst_complete = 1'b0;
            if (o_inst_valid) begin
                n_checks++;
                if (o_inst_pc !== 18'(got) || o_inst !== mem_word(18'(got)))
                    $display("FAIL stream_pop%0d pc=%0h inst=%0h exp pc=%0h inst=%0h", got, o_inst_pc, o_inst, got, mem_word(18'(got)));
                else n_pass++;
                i_inst_complete = 1'b1;
                got++;
            end
            @(negedge clk);
        end
        i_inst_complete = 1'b0;
        n_checks++; if (got != 8) $display("FAIL stream_count got=%0d exp=8", got); else n_pass++;
        wait_reqs(3, 30, ok);
        n_checks++; if (!ok) $display("FAIL stream_req_timeout reqs=%0d exp>=3", req_addr_q.size()); else n_pass++;
        for (int i = 0; i < 3 && ok; i++) begin
            n_checks++;
            if (req_addr_q[i] !== 18'(4 * i) || req_bc_q[i] !== 3'd4)
                $display("FAIL stream_req%0d addr=%0h bc=%0d exp addr=%0h bc=4", i, req_addr_q[i], req_bc_q[i], 4 * i);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        bit ok;
        bit any_read = 1'b0;
        do_reset();
        repeat (30) @(negedge clk);
        n_checks++; if (req_addr_q.size() != 2 || o_read !== 1'b0) $display("FAIL stall_full reqs=%0d read=%0b exp=2/0", req_addr_q.size(), o_read); else n_pass++;
        n_checks++; if (o_inst_valid !== 1'b1 || o_inst_pc !== 18'h0) $display("FAIL stall_head valid=%0b pc=%0h exp=1/0", o_inst_valid, o_inst_pc); else n_pass++;
        i_inst_complete = 1'b1;
        @(negedge clk);
        i_inst_complete = 1'b0;
        for (int t = 0; t < 10; t++) begin
            if (o_read) any_read = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (any_read || req_addr_q.size() != 2) $display("FAIL stall_one_pop read_seen=%0b reqs=%0d exp=0/2", any_read, req_addr_q.size()); else n_pass++;
        for (int p = 1; p <= 3; p++) begin
            n_checks++;
            if (o_inst_valid !== 1'b1 || o_inst_pc !== 18'(p)) $display("FAIL stall_pop%0d valid=%0b pc=%0h exp=1/%0h", p, o_inst_valid, o_inst_pc, p);
            else n_pass++;
            i_inst_complete = 1'b1;
            @(negedge clk);
        end
        i_inst_complete = 1'b0;
        wait_reqs(3, 20, ok);
        n_checks++; if (!ok || req_addr_q[2] !== 18'h8) $display("FAIL stall_refetch reqs=%0d addr=%0h exp=3/8", req_addr_q.size(), ok ? req_addr_q[2] : 18'h0); else n_pass++;
    endtask

    task automatic test_jr_mid_burst();
        bit ok = 1'b0;
        int nreq;
        do_reset();
        for (int t = 0; t < 30; t++) begin
            if (i_readdatavalid && i_readdata == mem_word(18'h1)) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++; if (!ok) $display("FAIL jr_beat2_timeout got=0 exp=1"); else n_pass++;
        nreq = req_addr_q.size();
        i_jr_valid = 1'b1; i_jr_addr = 18'h200;
        @(negedge clk);
        clear_inputs();
        n_checks++; if (o_rst_inst_fifo !== 1'b1 || o_inst_valid !== 1'b0) $display("FAIL jr_flush flush=%0b valid=%0b exp=1/0", o_rst_inst_fifo, o_inst_valid); else n_pass++;
        @(negedge clk);
        n_checks++; if (o_rst_inst_fifo !== 1'b0) $display("FAIL jr_flush_pulse got=%0b exp=0", o_rst_inst_fifo); else n_pass++;
        wait_reqs(nreq + 1, 30, ok);
        n_checks++; if (!ok || req_addr_q[nreq] !== 18'h200) $display("FAIL jr_next_addr ok=%0b addr=%0h exp=200", ok, ok ? req_addr_q[nreq] : 18'h0); else n_pass++;
        wait_valid(30, ok);
        n_checks++; if (!ok || o_inst_pc !== 18'h200 || o_inst !== 32'h300) $display("FAIL jr_first_inst pc=%0h inst=%0h exp=200/300", o_inst_pc, o_inst); else n_pass++;
    endtask

    task automatic test_wait_redirect();
        bit ok;
        bit addr_ok = 1'b1;
        int hold = 0;
        do_reset();
        repeat (30) @(negedge clk);
        forced_wait = 3;
        i_inst_complete = 1'b1;
        repeat (4) @(negedge clk);
        i_inst_complete = 1'b0;
        wait_read(20, ok);
        n_checks++; if (!ok) $display("FAIL wait_req_timeout got=0 exp=1"); else n_pass++;
        i_j_valid = 1'b1; i_j_addr = 18'h40;
        for (int t = 0; t < 20 && o_read; t++) begin
            if (o_addr !== 18'h8) addr_ok = 1'b0;
            hold++;
            @(negedge clk);
            clear_inputs();
        end
        clear_inputs();
        n_checks++; if (!addr_ok || hold != 4) $display("FAIL wait_hold addr_stable=%0b cycles=%0d exp=1/4", addr_ok, hold); else n_pass++;
        wait_reqs(4, 40, ok);
        n_checks++; if (!ok || req_addr_q[2] !== 18'h8 || req_addr_q[3] !== 18'h40)
            $display("FAIL wait_refetch ok=%0b addr2=%0h addr3=%0h exp=8/40", ok, ok ? req_addr_q[2] : 18'h0, ok ? req_addr_q[3] : 18'h0); else n_pass++;
        wait_valid(30, ok);
        n_checks++; if (!ok || o_inst_pc !== 18'h40 || o_inst !== 32'h140) $display("FAIL wait_first_inst pc=%0h inst=%0h exp=40/140", o_inst_pc, o_inst); else n_pass++;
    endtask

    task automatic test_priority();
        bit ok;
        do_reset();
        wait_read(20, ok);
        i_jr_valid = 1'b1; i_jr_addr = 18'h10; i_j_valid = 1'b1; i_j_addr = 18'h20;
        @(negedge clk);
        clear_inputs();
        wait_valid(40, ok);
        n_checks++; if (!ok || o_inst_pc !== 18'h10 || o_inst !== 32'h110) $display("FAIL prio_jr_over_j pc=%0h inst=%0h exp=10/110", o_inst_pc, o_inst); else n_pass++;
        i_inst_complete = 1'b1;
        @(negedge clk);
        i_inst_complete = 1'b0;
        wait_valid(20, ok);
        n_checks++; if (!ok || o_inst_pc !== 18'h11) $display("FAIL prio_next pc=%0h exp=11", o_inst_pc); else n_pass++;
        i_jal_valid = 1'b1; i_jal_addr = 18'h30; i_j_valid = 1'b1; i_j_addr = 18'h50;
        @(negedge clk);
        clear_inputs();
        wait_valid(40, ok);
        n_checks++; if (!ok || o_inst_pc !== 18'h30) $display("FAIL prio_jal_over_j pc=%0h exp=30", o_inst_pc); else n_pass++;
    endtask

    task automatic test_jal_link();
        bit ok;
        do_reset();
        wait_valid(20, ok);
        i_jr_valid = 1'b1; i_jr_addr = 18'h3FFFE;
        @(negedge clk);
        clear_inputs();
        wait_valid(40, ok);
        n_checks++; if (!ok || o_inst_pc !== 18'h3FFFE) $display("FAIL jal_setup pc=%0h exp=3fffe", o_inst_pc); else n_pass++;
        i_inst_complete = 1'b1;
        @(negedge clk);
        i_inst_complete = 1'b0;
        wait_valid(20, ok);
        n_checks++; if (!ok || o_inst_pc !== 18'h3FFFF) $display("FAIL jal_head pc=%0h exp=3ffff", o_inst_pc); else n_pass++;
        i_jal_valid = 1'b1; i_jal_addr = 18'h80; i_inst_complete = 1'b1;
        @(negedge clk);
        clear_inputs();
`ifdef INST_FETCH_JAL_LINK_EN
        n_checks++; if (o_ret_addr !== 18'h0 || o_ret_addr_valid !== 1'b1) $display("FAIL jal_link ret=%0h valid=%0b exp=0/1", o_ret_addr, o_ret_addr_valid); else n_pass++;
`else
        n_checks++; if (o_ret_addr !== 18'h0 || o_ret_addr_valid !== 1'b0) $display("FAIL jal_nolink ret=%0h valid=%0b exp=0/0", o_ret_addr, o_ret_addr_valid); else n_pass++;
`endif
        n_checks++; if (o_rst_inst_fifo !== 1'b1) $display("FAIL jal_flush got=%0b exp=1", o_rst_inst_fifo); else n_pass++;
        @(negedge clk);
        n_checks++; if (o_ret_addr_valid !== 1'b0) $display("FAIL jal_pulse_len got=%0b exp=0", o_ret_addr_valid); else n_pass++;
        wait_valid(40, ok);
        n_checks++; if (!ok || o_inst_pc !== 18'h80) $display("FAIL jal_target pc=%0h exp=80", o_inst_pc); else n_pass++;
    endtask

    // Consumer-visible stream after any redirect is target, target+1, ...
    task automatic test_random();
        logic [17:0] exp_pc = '0;
        logic [17:0] prev_addr = '0;
        logic [17:0] ta, tb, tc;
        logic [2:0]  sel;
        bit flush_exp = 1'b0, prev_rw = 1'b0, redir, pop;
        int pops = 0;
        do_reset();
        wait_pct = 30; gap_pct = 30;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            n_checks++; if (o_rst_inst_fifo !== flush_exp) $display("FAIL rnd_flush cyc=%0d got=%0b exp=%0b", cyc, o_rst_inst_fifo, flush_exp); else n_pass++;
            if (flush_exp) begin
                n_checks++; if (o_inst_valid !== 1'b0) $display("FAIL rnd_flush_valid cyc=%0d got=%0b exp=0", cyc, o_inst_valid); else n_pass++;
            end
            if (prev_rw) begin
                n_checks++; if (o_read !== 1'b1 || o_addr !== prev_addr) $display("FAIL rnd_hold cyc=%0d read=%0b addr=%0h exp=1/%0h", cyc, o_read, o_addr, prev_addr); else n_pass++;
            end
            if (o_read) begin
                n_checks++; if (o_burstcount !== 3'd4) $display("FAIL rnd_bc cyc=%0d got=%0d exp=4", cyc, o_burstcount); else n_pass++;
            end
            clear_inputs();
            redir = ($urandom_range(99) < 3);
            pop   = ($urandom_range(99) < 60);
            if (redir) begin
                sel = 3'($urandom_range(7, 1));
                ta = 18'($urandom); tb = 18'($urandom); tc = 18'($urandom);
                i_jr_valid = sel[0]; i_jr_addr = ta;
                i_jal_valid = sel[1]; i_jal_addr = tb;
                i_j_valid = sel[2]; i_j_addr = tc;
                exp_pc = sel[0] ? ta : (sel[1] ? tb : tc);
            end
            i_inst_complete = pop;
            if (pop && o_inst_valid && !redir) begin
                n_checks++;
                if (o_inst_pc !== exp_pc || o_inst !== mem_word(exp_pc))
                    $display("FAIL rnd_pop cyc=%0d pc=%0h inst=%0h exp pc=%0h inst=%0h", cyc, o_inst_pc, o_inst, exp_pc, mem_word(exp_pc));
                else n_pass++;
                exp_pc = exp_pc + 18'd1;
                pops++;
            end
            flush_exp = redir;
            prev_rw   = o_read && i_waitrequest;
            prev_addr = o_addr;
            @(negedge clk);
        end
        clear_inputs();
        wait_pct = 0; gap_pct = 0;
        n_checks++; if (pops < 50) $display("FAIL rnd_progress pops=%0d exp>=50", pops); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_jr_mid_burst();
        test_wait_redirect();
        test_priority();
        test_jal_link();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_fetch_burst_ctrl.md
# inst_fetch_burst_ctrl

Parametrised instruction fetch controller between the Avalon-MM instruction memory and the decode stage. It issues fixed-length burst reads ahead of execution into a show-ahead instruction FIFO and accepts jr/j/jal redirects. On a redirect it flushes the FIFO, discards stale in-flight beats and refetches from the target. Unlike the previous generation, burst length, FIFO depth and address width are parameters, every delivered instruction carries its PC, and flow control is credit-based.

## Interface
- P_ADDR_BITS, 18, word address width
- P_INST_BITS, 32, instruction width
- P_FIFO_DEPTH, 8, FIFO entries; power of two, >= P_BURST_LEN
- P_FIFO_DEPTH_LOG2, 3, log2(P_FIFO_DEPTH)
- P_BURST_LEN, 4, words per burst, 1..P_FIFO_DEPTH
- P_BURST_BITS, 3, width of o_burstcount; holds P_BURST_LEN
- P_RESET_PC, 0, fetch address after reset

- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- i_jr_addr / i_j_addr / i_jal_addr  in  P_ADDR_BITS  redirect targets
- i_jr_valid / i_j_valid / i_jal_valid  in  1  redirect strobes
- o_ret_addr  out  P_ADDR_BITS  link address for jal
- o_ret_addr_valid  out  1  one-cycle pulse with o_ret_addr
- o_inst  out  P_INST_BITS  FIFO head instruction
- o_inst_pc  out  P_ADDR_BITS  word address of o_inst
- o_inst_valid  out  1  head valid
- i_inst_complete  in  1  consume head
- o_inst_empty  out  1  FIFO empty
- o_rst_inst_fifo  out  1  one-cycle flush pulse
- o_addr  out  P_ADDR_BITS  Avalon address
- o_burstcount  out  P_BURST_BITS  Avalon burstcount, constant P_BURST_LEN
- o_read  out  1  Avalon read
- i_waitrequest  in  1  Avalon waitrequest
- i_readdata  in  P_INST_BITS  Avalon read data
- i_readdatavalid  in  1  Avalon beat valid

## Operation
- State machine IDLE, REQ, DATA. Reset enters IDLE with fetch PC = P_RESET_PC.
- IDLE -> REQ when FIFO free slots >= P_BURST_LEN. Only one burst is outstanding at a time, so the FIFO never overflows.
- REQ: o_read=1 and o_addr=fetch PC are held stable while i_waitrequest=1. On acceptance: fetch PC += P_BURST_LEN (mod 2^P_ADDR_BITS), beat count = 0, go to DATA.
- DATA: each i_readdatavalid beat increments the beat count. The beat is written to the FIFO with its PC unless the discard flag is set. At beat P_BURST_LEN go to IDLE and clear discard.
- Pop: i_inst_complete && o_inst_valid. i_inst_complete with an empty FIFO is ignored.
- Redirect priority is jr > jal > j; lower-priority strobes in the same cycle are ignored. A redirect is honoured in any state and has these effects:
  - fetch PC = target;
  - FIFO flushed and o_rst_inst_fifo pulsed;
  - a simultaneous beat or pop is dropped;
  - if in REQ or DATA, discard is set.
- Redirect in REQ: the command stays held unchanged until accepted (Avalon rule), then all beats are discarded. A redirect in IDLE takes effect with no discard.
- Further redirects while discard is set only update fetch PC.
- Addresses wrap modulo 2^P_ADDR_BITS, with no burst alignment.
- Reset asserted mid-burst: all state clears immediately. Any beats still in flight are the memory's concern and the system resets it together with this block.

## Timing
- Reset values:
  - o_read=0, o_addr=P_RESET_PC, o_burstcount=P_BURST_LEN;
  - o_inst_valid=0, o_inst_empty=1, o_inst=0, o_inst_pc=0;
  - o_rst_inst_fifo=0, o_ret_addr=0, o_ret_addr_valid=0.
- o_read is registered and rises the first cycle after rst deasserts.
- FIFO is show-ahead: a beat written in cycle N appears on o_inst/o_inst_valid in N+1.
- A flush takes effect on the following edge: o_inst_valid=0 in cycle N+1 for a redirect in N, and o_rst_inst_fifo=1 in N+1.
- With zero-wait memory and data one cycle after acceptance, the next burst request follows the last beat by 1 cycle (DATA -> IDLE -> REQ).

## Configuration
- INST_FETCH_JAL_LINK_EN defined:
  - o_ret_addr = o_inst_pc + 1 and o_ret_addr_valid pulses in the cycle after i_jal_valid is honoured.
  - i_jal_valid must coincide with i_inst_complete on the jal head.
- INST_FETCH_JAL_LINK_EN undefined: o_ret_addr=0 and o_ret_addr_valid=0 constantly; jal behaves exactly like j.

## Structure
- Shared package/define file holds the FSM state encodings (IDLE/REQ/DATA) and the INST_BITS default.
- One sub-module, inst_fetch_fifo: a show-ahead FIFO with async active-low reset, a synchronous flush, and a free-slot count output. Entries are {pc, inst}.

## Test plan
- Reset release, zero-wait memory returning data 0x100+addr: o_addr 0, 4, 8 with burstcount 4; o_inst_pc 0..7 in order; o_inst = 0x100..0x107.
- Consumer stalled: FIFO holds 8 entries; no o_read while free slots < 4. A single pop does not trigger a fetch; a fourth pop does.
- jr to 0x200 during DATA beat 2: remaining beats dropped; o_rst_inst_fifo pulses once; next o_addr=0x200; first o_inst_pc=0x200.
- i_waitrequest high 3 cycles with j to 0x40 in the first cycle: o_addr unchanged until accepted, all 4 beats discarded, then request at 0x40.
- Simultaneous jr=0x10 and j=0x20: fetch resumes at 0x10.
- With INST_FETCH_JAL_LINK_EN, jal at head PC 0x3FFFF: o_ret_addr=0 (wrap) with a one-cycle o_ret_addr_valid pulse. Without the macro, both stay 0.
